// File: rtl/mem_pkg.sv
// Shared bus encodings, tag width and load-pipeline entry layout for the
// instruction-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam int MEM_TAG_W = 4;
    // Wide enough for any legal MEM_WORDS; the top slices it to log2(MEM_WORDS).
    localparam int MEM_IDX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [MEM_TAG_W-1:0] tag;
        logic [MEM_IDX_W-1:0] idx;
    } pipe_entry_t;

endpackage

// File: rtl/mem_tag_alloc.sv
// Load-tag allocator: busy vector with a lowest-free priority encoder.
// Tag n corresponds to busy bit n-1; tag 0 is never granted.
module mem_tag_alloc
    import mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_i,
    input  logic                 free_i,
    input  logic [MEM_TAG_W-1:0] free_tag_i,
    output logic                 any_free_o,
    output logic [MEM_TAG_W-1:0] grant_tag_o
);

    logic [MAX_OUTSTANDING-1:0] busy_q;
    logic [MAX_OUTSTANDING-1:0] busy_d;

    always_comb begin
        any_free_o  = 1'b0;
        grant_tag_o = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free_o  = 1'b1;
                grant_tag_o = MEM_TAG_W'(i + 1);
            end
        end
    end

    // Clear is applied after set so a clear only ever overrides its own bit.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (alloc_i && any_free_o && grant_tag_o == MEM_TAG_W'(i + 1)) begin
                busy_d[i] = 1'b1;
            end
            if (free_i && free_tag_i == MEM_TAG_W'(i + 1)) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: tags loads, completes them after a fixed latency
// from an on-chip 64-bit word array, and accepts untagged stores.
module imem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY         = 10,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MEM_WORDS       = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           proc2mem_command_i,
    input  logic [63:0]          proc2mem_addr_i,
    input  logic [63:0]          proc2mem_data_i,
    output logic [MEM_TAG_W-1:0] mem2proc_response_o,
    output logic [63:0]          mem2proc_data_o,
    output logic [MEM_TAG_W-1:0] mem2proc_tag_o,
    output logic [3:0]           mem2proc_outstanding_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]          mem_q [MEM_WORDS];
    pipe_entry_t          pipe_q [LATENCY];
    pipe_entry_t          new_entry;
    pipe_entry_t          comp;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           st_cnt_q, st_cnt_d;

    logic                 in_range;
    logic [IDX_W-1:0]     word_idx;
    logic                 load_acc;
    logic                 store_acc;
    logic                 any_free;
    logic [MEM_TAG_W-1:0] grant_tag;
    logic                 unused_bits;

    assign unused_bits = ^{proc2mem_addr_i[2:0], comp.idx[MEM_IDX_W-1:IDX_W]};

    // Nothing is accepted while reset is held, so the array cannot be written then.
    assign in_range  = rst && ({3'b000, proc2mem_addr_i[63:3]} < 64'(MEM_WORDS));
    assign word_idx  = proc2mem_addr_i[3+IDX_W-1:3];
    assign load_acc  = in_range && (proc2mem_command_i == BUS_LOAD) && any_free;
    assign store_acc = in_range && (proc2mem_command_i == BUS_STORE);

    assign comp = pipe_q[LATENCY-1];

    mem_tag_alloc #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_tag_alloc (
        .clk        (clk),
        .rst        (rst),
        .alloc_i    (load_acc),
        .free_i     (comp.valid),
        .free_tag_i (comp.tag),
        .any_free_o (any_free),
        .grant_tag_o(grant_tag)
    );

    always_comb begin
        mem2proc_response_o = '0;
        if (load_acc) begin
            mem2proc_response_o = grant_tag;
        end else if (store_acc) begin
            mem2proc_response_o = st_cnt_q;
        end
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = load_acc;
        new_entry.tag   = grant_tag;
        new_entry.idx   = MEM_IDX_W'(word_idx);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_acc && !comp.valid) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!load_acc && comp.valid) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Store counter walks 1..15 and never produces the "not accepted" value 0.
    assign st_cnt_d = !store_acc        ? st_cnt_q :
                      (st_cnt_q == 4'd15) ? 4'd1 : st_cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            cnt_q    <= '0;
            st_cnt_q <= 4'd1;
        end else begin
            pipe_q[0] <= new_entry;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            cnt_q    <= cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Array contents survive reset, so it lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem_q[word_idx] <= proc2mem_data_i;
        end
    end

    assign mem2proc_tag_o         = comp.valid ? comp.tag : '0;
    assign mem2proc_data_o        = comp.valid ? mem_q[comp.idx[IDX_W-1:0]] : 64'd0;
    assign mem2proc_outstanding_o = cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: default configuration plus a
// LATENCY=1 / MAX_OUTSTANDING=1 instance sharing clock and reset.
module tb_imem_responder;

  localparam int LAT = 10;
  localparam int MEM_WORDS = 8192;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd_i;
  logic [63:0] addr_i;
  logic [63:0] data_i;
  logic [3:0]  resp_o;
  logic [63:0] rdata_o;
  logic [3:0]  tag_o;
  logic [3:0]  outst_o;

  logic [1:0]  d1_cmd;
  logic [63:0] d1_addr;
  logic [63:0] d1_data;
  logic [3:0]  d1_resp;
  logic [63:0] d1_rdata;
  logic [3:0]  d1_tag;
  logic [3:0]  d1_outst;

  typedef struct {
    logic [3:0] tag;
    int         idx;
    int         due;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [int];
  logic [3:0]  st_exp;
  int          cyc_n;
  int          n_tests;
  int          n_fail;

  imem_responder dut (
    .clk                   (clk),
    .rst                   (rst),
    .proc2mem_command_i    (cmd_i),
    .proc2mem_addr_i       (addr_i),
    .proc2mem_data_i       (data_i),
    .mem2proc_response_o   (resp_o),
    .mem2proc_data_o       (rdata_o),
    .mem2proc_tag_o        (tag_o),
    .mem2proc_outstanding_o(outst_o)
  );

  imem_responder #(.LATENCY(1), .MAX_OUTSTANDING(1), .MEM_WORDS(MEM_WORDS)) dut1 (
    .clk                   (clk),
    .rst                   (rst),
    .proc2mem_command_i    (d1_cmd),
    .proc2mem_addr_i       (d1_addr),
    .proc2mem_data_i       (d1_data),
    .mem2proc_response_o   (d1_resp),
    .mem2proc_data_o       (d1_rdata),
    .mem2proc_tag_o        (d1_tag),
    .mem2proc_outstanding_o(d1_outst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Completion and outstanding checks against the scoreboard for the current cycle.
  task automatic check_out();
    chk("outstanding", 64'(outst_o), 64'(exp_q.size()));
    if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
      chk("comp_tag", 64'(tag_o), 64'(exp_q[0].tag));
      chk("comp_data", rdata_o, model[exp_q[0].idx]);
      void'(exp_q.pop_front());
    end else begin
      chk("idle_tag", 64'(tag_o), 64'd0);
      chk("idle_data", rdata_o, 64'd0);
    end
  endtask

  // One bus cycle: drive, check mid-cycle, then record the accepting edge.
  task automatic cyc(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                     input logic [3:0] exp_load_resp);
    logic [3:0] er;
    logic       inr;
    exp_t       e;
    cmd_i  = cmd;
    addr_i = addr;
    data_i = data;
    inr = (addr[63:3] < 61'(MEM_WORDS));
    er = 4'd0;
    if (cmd == 2'd1 && inr) er = exp_load_resp;
    else if (cmd == 2'd2 && inr) er = st_exp;
    @(negedge clk);
    chk("response", 64'(resp_o), 64'(er));
    check_out();
    @(posedge clk);
    if (cmd == 2'd2 && inr) begin
      model[int'(addr[15:3])] = data;
      st_exp = (st_exp == 4'd15) ? 4'd1 : st_exp + 4'd1;
    end
    if (cmd == 2'd1 && er != 4'd0) begin
      e.tag = er;
      e.idx = int'(addr[15:3]);
      e.due = cyc_n + LAT;
      exp_q.push_back(e);
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 64'd0, 64'd0, 4'd0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 64) begin
      idle(1);
      g++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    idle(1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc_n   = 0;
    st_exp  = 4'd1;
    rst     = 1'b0;
    cmd_i   = 2'd0;
    addr_i  = '0;
    data_i  = '0;
    d1_cmd  = 2'd0;
    d1_addr = '0;
    d1_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_data", rdata_o, 64'd0);
    chk("rst_resp", 64'(resp_o), 64'd0);
    chk("rst_outst", 64'(outst_o), 64'd0);
    rst = 1'b1;

    // Store, idle, load: completion exactly LAT cycles after the accept edge.
    cyc(2'd2, 64'h100, 64'hDEADBEEF_00000001, 4'd0);
    idle(1);
    cyc(2'd1, 64'h100, 64'd0, 4'd1);
    drain();

    // Back-to-back loads exhaust the tag pool.
    for (int i = 0; i < 9; i++) cyc(2'd2, 64'h100 + 64'(8 * i), {$urandom, $urandom}, 4'd0);
    for (int i = 0; i < 9; i++) cyc(2'd1, 64'h100 + 64'(8 * i), 64'd0, (i < 8) ? 4'(i + 1) : 4'd0);
    chk("outst_full", 64'(outst_o), 64'd8);
    idle(1);
    cyc(2'd1, 64'h100, 64'd0, 4'd0);
    cyc(2'd1, 64'h108, 64'd0, 4'd1);
    drain();

    // Store-after-load ordering at the same word.
    cyc(2'd2, 64'h200, {$urandom, $urandom}, 4'd0);
    cyc(2'd1, 64'h200, 64'd0, 4'd1);
    idle(4);
    cyc(2'd2, 64'h200, 64'h5, 4'd0);
    idle(4);
    chk("pre_comp_model", model[64], 64'h5);
    cyc(2'd2, 64'h200, 64'h77, 4'd0);
    drain();

    // Out-of-range and command 3 leave all state alone.
    cyc(2'd1, 64'h10000, 64'd0, 4'd0);
    cyc(2'd3, 64'h100, 64'd0, 4'd0);
    cyc(2'd2, 64'h10000, 64'h1234, 4'd0);
    cyc(2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 4'd0);
    cyc(2'd2, 64'h1F8, 64'hCAFE, 4'd0);
    idle(LAT + 2);

    // Asynchronous reset with three loads in flight.
    for (int i = 0; i < 3; i++) cyc(2'd1, 64'h100 + 64'(8 * i), 64'd0, 4'(i + 1));
    cmd_i  = 2'd1;
    addr_i = 64'h100;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tag", 64'(tag_o), 64'd0);
    chk("arst_data", rdata_o, 64'd0);
    chk("arst_resp", 64'(resp_o), 64'd0);
    chk("arst_outst", 64'(outst_o), 64'd0);
    exp_q.delete();
    st_exp = 4'd1;
    cmd_i  = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * LAT);
    cyc(2'd1, 64'h100, 64'd0, 4'd1);
    cyc(2'd1, 64'h1F8, 64'd0, 4'd2);
    drain();

    // Minimal configuration: one tag, one-cycle latency.
    d1_cmd  = 2'd2;
    d1_addr = 64'h100;
    d1_data = 64'hA5A5_0000_1111_2222;
    @(negedge clk);
    chk("d1_store_resp", 64'(d1_resp), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      d1_cmd  = 2'd1;
      d1_addr = 64'h100;
      @(negedge clk);
      chk("d1_resp", 64'(d1_resp), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("d1_tag", 64'(d1_tag), (k % 2 == 1) ? 64'd1 : 64'd0);
      chk("d1_data", d1_rdata, (k % 2 == 1) ? 64'hA5A5_0000_1111_2222 : 64'd0);
      chk("d1_outst", 64'(d1_outst), (k % 2 == 1) ? 64'd1 : 64'd0);
      @(posedge clk);
      #1;
    end
    d1_cmd = 2'd0;
    @(negedge clk);
    chk("d1_final_tag", 64'(d1_tag), 64'd0);
    chk("d1_final_outst", 64'(d1_outst), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the processor bus driven by the Icache (command/addr out; response/tag/data back).
- Accepts BUS_LOAD/BUS_STORE commands and returns a nonzero response tag the same cycle.
- Completes each accepted load a fixed LATENCY cycles later by presenting the data together with its tag for exactly one cycle.
- Backed by an on-chip 64-bit word array; serves as the memory model for fetch-path simulation and as the template for the real memory controller.

Parameters:
LATENCY, 10, cycles from load acceptance edge to data/tag presentation; legal range 1..32
MAX_OUTSTANDING, 8, maximum loads in flight; tags 1..MAX_OUTSTANDING are used; legal range 1..15
MEM_WORDS, 8192, number of 64-bit words; address range 0..MEM_WORDS*8-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
proc2mem_command_i  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; 3 is treated as BUS_NONE
proc2mem_addr_i  in  64  byte address; bits [2:0] ignored
proc2mem_data_i  in  64  store data
mem2proc_response_o  out  4  accepting tag this cycle; 0 = not accepted
mem2proc_data_o  out  64  load data, valid only when mem2proc_tag_o != 0
mem2proc_tag_o  out  4  completing tag; 0 = no completion this cycle
mem2proc_outstanding_o  out  4  count of loads in flight (debug/verification)

Behaviour:
- Reset (rst=0, async):
  - Pipeline valids cleared, all tags freed, outstanding=0.
  - response/tag/data outputs 0.
  - Memory array contents NOT reset and retained across reset.
  - A reset mid-operation drops all in-flight loads silently; no completion is ever produced for them.
- Range check: in_range = (addr[63:3] < MEM_WORDS); word index = addr[3+log2(MEM_WORDS)-1:3].
- Load acceptance, combinational, same cycle:
  - Accept iff command==BUS_LOAD, in_range, and a free tag exists.
  - response = lowest-numbered free tag; otherwise response=0 and the request is dropped (initiator retries).
- Load capture: at the accepting edge, the tag is marked busy and {valid,tag,idx} enters stage 0 of a LATENCY-deep shift pipeline.
- Load completion:
  - When the entry reaches the last stage (LATENCY cycles after the accept edge), tag_o = tag and data_o = array[idx] for one cycle, read combinationally.
  - Otherwise tag_o=0, data_o=0.
  - Fixed latency plus at most one accept per cycle guarantees at most one completion per cycle.
- Tag free: a tag completing in cycle N is freed at the end-of-N edge and is allocatable from cycle N+1, never in N.
- Store:
  - Accepted iff command==BUS_STORE and in_range; no tag limit applies.
  - response = 1..15 via a rotating 4-bit store counter that skips 0; the counter advances per accepted store.
  - Array written at the accepting edge. No completion is ever issued for stores and no tag is occupied.
- Ordering:
  - A load completing in cycle N returns array contents as of the start of N.
  - A store accepted in cycle N is visible to completions from N+1.
  - A store accepted in cycle N-k (k≥1) is visible to any load completing at N, regardless of load accept order.
- Out-of-range load/store: response=0, no state change.
- outstanding_o:
  - +1 on load accept, -1 on completion.
  - Simultaneous accept and completion leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Command 3 / BUS_NONE: response=0, no state change.

Decomposition:
- Shared package (mem_pkg):
  - BUS_NONE/BUS_LOAD/BUS_STORE enum (2 bits).
  - MEM_TAG_W=4.
  - Pipeline entry struct {valid, tag, idx}.
- Sub-module mem_tag_alloc:
  - MAX_OUTSTANDING-bit busy vector.
  - Lowest-free priority encoder with a combinational grant tag and any_free output.
  - Set-on-allocate and clear-on-free ports.
  - Clear wins only for its own bit; allocate and free in the same cycle are for different tags by construction.

Test Plan:
- Store 0xDEADBEEF_00000001 to 0x100, then one idle cycle, then load 0x100 → store response nonzero; load response=1; tag_o=1 with data 0xDEADBEEF_00000001 exactly 10 cycles after the load accept edge, tag_o=0 before and after.
- Back-to-back loads on 9 consecutive cycles with 0 completions in between → responses 1..8, 9th response=0, outstanding_o=8; the first completion (tag 1) arrives at cycle 10, and a retry on cycle 11 gets tag 1.
- Load 0x200 accepted at cycle 0, store 0x5 to 0x200 at cycle 5 → completion at cycle 10 returns 0x5; a store at cycle 10 to 0x200 is not reflected in the completing data.
- Load with addr = MEM_WORDS*8 (0x10000), and command=3 → response=0, outstanding_o unchanged, no completion ever produced.
- Assert rst=0 asynchronously mid-cycle with 3 loads in flight → outputs 0 immediately; after release, no completions within 2*LATENCY cycles; the next load receives tag 1; previously stored data is still readable.
- Re-run the back-to-back test with LATENCY=1, MAX_OUTSTANDING=1 → loads every cycle alternate response 1/0 (a tag completing in N is not reused in N); data returned the cycle after accept.
